// File: rtl/aes_128_dec_iter_pkg.sv
// AES-128 iterative decryptor: shared widths, FSM state encoding and the
// key-schedule round constants.
package aes_dec_pkg;
    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int NR      = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEYX  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Index 1 holds rcon_1; entry 0 does not exist.
    localparam logic [10:1][BYTE_W-1:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [BYTE_W-1:0] rcon_at(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return RCON[idx];
        end
        return '0;
    endfunction
endpackage

// File: rtl/aes_128_dec_iter_if.sv
// Request/response bus of the AES-128 decryptor: ciphertext+key in, plaintext out.
interface aes_128_dec_iter_if;
    import aes_dec_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] ct;
    logic [BLOCK_W-1:0] key;
    logic               new_key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] pt;

    modport slave (
        input  in_valid, ct, key, new_key, out_ready,
        output in_ready, out_valid, pt
    );

    modport master (
        output in_valid, ct, key, new_key, out_ready,
        input  in_ready, out_valid, pt
    );
endinterface

// File: rtl/aes_128_dec_iter_sbox.sv
// AES S-box, forward or inverse, built from GF(2^8) inversion and the affine maps.
module aes_sbox
    import aes_dec_pkg::*;
(
    input  logic              inv,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse and conveniently maps 0 to 0.
    function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] sq;
        logic [BYTE_W-1:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < BYTE_W; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [BYTE_W-1:0] affine_fwd(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] o;
        o = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        end
        return o ^ 8'h63;
    endfunction

    function automatic logic [BYTE_W-1:0] affine_inv(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] o;
        o = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            o[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return o ^ 8'h05;
    endfunction

    logic [BYTE_W-1:0] pre;
    logic [BYTE_W-1:0] inv_b;

    always_comb begin
        pre   = inv ? affine_inv(din) : din;
        inv_b = gf_inv(pre);
        dout  = inv ? inv_b : affine_fwd(inv_b);
    end

endmodule

// File: rtl/aes_128_dec_iter.sv
// AES-128 iterative decryptor: one inverse round per clock with an on-the-fly
// inverse key schedule; the last round key is cached between requests.
module aes_128_dec_iter
    import aes_dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_128_dec_iter_if.slave bus
);

    state_e             state;
    logic [3:0]         rnd;
    logic               key_cached;
    logic [BLOCK_W-1:0] rk10_cache;
    logic [BLOCK_W-1:0] data;
    logic [BLOCK_W-1:0] kreg;
    logic [BLOCK_W-1:0] ct_reg;

    logic [BLOCK_W-1:0] sr, sb, rk_fwd, rk_inv, round_out, final_out;
    logic [WORD_W-1:0]  w0, w1, w2, w3, w1_i, w2_i, w3_i;
    logic [WORD_W-1:0]  f0, f1, f2, f3;
    logic [WORD_W-1:0]  sub_in, sub_out, rcon_word;
    logic               accept, expand;

    function automatic logic [BYTE_W-1:0] xt(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] mul9(input logic [BYTE_W-1:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [BYTE_W-1:0] mulb(input logic [BYTE_W-1:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [BYTE_W-1:0] muld(input logic [BYTE_W-1:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [BYTE_W-1:0] mule(input logic [BYTE_W-1:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Byte n sits at bits [127-8n -: 8], column-major: row = n%4, column = n/4.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[BLOCK_W-1-BYTE_W*(4*c+r) -: BYTE_W] =
                    s[BLOCK_W-1-BYTE_W*(4*((c-r+4)%4)+r) -: BYTE_W];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [BYTE_W-1:0]  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[BLOCK_W-1-WORD_W*c -: WORD_W];
            o[BLOCK_W-1-WORD_W*c -: WORD_W] = {
                mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)
            };
        end
        return o;
    endfunction

    // Key schedule: forward step while expanding, inverse step while decrypting.
    // Both share one SubWord; the inverse step feeds it the recovered w3.
    assign {w0, w1, w2, w3} = kreg;
    assign w3_i = w3 ^ w2;
    assign w2_i = w2 ^ w1;
    assign w1_i = w1 ^ w0;

    assign sub_in    = (state == KEYX) ? {w3[23:0], w3[31:24]} : {w3_i[23:0], w3_i[31:24]};
    assign rcon_word = {rcon_at((state == KEYX) ? rnd : rnd + 4'd1), 24'h0};

    assign f0     = w0 ^ sub_out ^ rcon_word;
    assign f1     = w1 ^ f0;
    assign f2     = w2 ^ f1;
    assign f3     = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};
    assign rk_inv = {f0, w1_i, w2_i, w3_i};

    for (genvar i = 0; i < 4; i++) begin : g_fwd_sbox
        aes_sbox u_sbox (
            .inv  (1'b0),
            .din  (sub_in[WORD_W-1-BYTE_W*i -: BYTE_W]),
            .dout (sub_out[WORD_W-1-BYTE_W*i -: BYTE_W])
        );
    end

    // Data path: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    assign sr = inv_shift_rows(data);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_sbox u_sbox (
            .inv  (1'b1),
            .din  (sr[BLOCK_W-1-BYTE_W*i -: BYTE_W]),
            .dout (sb[BLOCK_W-1-BYTE_W*i -: BYTE_W])
        );
    end

    assign final_out = sb ^ rk_inv;
    assign round_out = inv_mix_columns(final_out);

    assign accept        = (state == IDLE) && bus.in_valid;
    assign expand        = bus.new_key || !key_cached;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.pt        = data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rnd        <= 4'd0;
            key_cached <= 1'b0;
            rk10_cache <= '0;
            data       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (expand) begin
                            rnd   <= 4'd1;
                            state <= KEYX;
                        end else begin
                            data  <= bus.ct ^ rk10_cache;
                            rnd   <= 4'(NR - 1);
                            state <= ROUND;
                        end
                    end
                end
                KEYX: begin
                    if (rnd == 4'(NR)) begin
                        rk10_cache <= rk_fwd;
                        key_cached <= 1'b1;
                        data       <= ct_reg ^ rk_fwd;
                        rnd        <= 4'(NR - 1);
                        state      <= ROUND;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ROUND: begin
                    data <= round_out;
                    if (rnd == 4'd1) begin
                        rnd   <= 4'd0;
                        state <= FINAL;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                FINAL: begin
                    data  <= final_out;
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working key and latched ciphertext carry no reset; they are always
    // reloaded on the accepting edge before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            ct_reg <= bus.ct;
            kreg   <= expand ? bus.key : rk10_cache;
        end else if (state == KEYX) begin
            kreg <= rk_fwd;
        end else if (state == ROUND) begin
            kreg <= rk_inv;
        end
    end

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Bench for aes_128_dec_iter: FIPS-197 vectors, backpressure and reset corner
// cases, then random requests checked against a table-based AES model.
module tb_aes_128_dec_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] JUNK   = 128'hdeadbeefcafef00d0badc0de5a5aa5a5;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    aes_128_dec_iter_if bus ();

    aes_128_dec_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic         nk;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    vec_t vecs [5];

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic         model_cached;
    logic [127:0] model_key;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Builds the S-box by walking GF(2^8) with generator 3 and its inverse,
    // then inverts the table to get the inverse S-box.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = i[7:0];
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Textbook inverse cipher: full forward key expansion, then rounds 10..0.
    function automatic logic [127:0] model_decrypt(input logic [127:0] c, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [4][4];
        logic [7:0]   u [4][4];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                s[row][col] = c[127-8*(4*col+row) -: 8] ^ w[40+col][31-8*row -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    u[row][col] = isbox[s[row][(col-row+4)%4]];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    s[row][col] = u[row][col] ^ w[4*rd+col][31-8*row -: 8];
            if (rd > 0) begin
                for (int col = 0; col < 4; col++) begin
                    for (int row = 0; row < 4; row++) a[row] = s[row][col];
                    for (int row = 0; row < 4; row++)
                        s[row][col] = gmul(a[row], 8'h0e) ^ gmul(a[(row+1)%4], 8'h0b)
                                    ^ gmul(a[(row+2)%4], 8'h0d) ^ gmul(a[(row+3)%4], 8'h09);
                end
            end
        end
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                o[127-8*(4*col+row) -: 8] = s[row][col];
        return o;
    endfunction

    // Tracks the cache and returns the expected accept-to-out_valid latency.
    function automatic int model_accept(input logic [127:0] k, input logic nk);
        if (nk || !model_cached) begin
            model_cached = 1'b1;
            model_key    = k;
            return 20;
        end
        return 10;
    endfunction

    task automatic run_req(input string tag, input logic [127:0] c, input logic [127:0] k,
                           input logic nk, input logic [127:0] exp_pt, input int exp_lat,
                           input int hold);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " in_ready"}, 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b1;
        bus.ct       = c;
        bus.key      = k;
        bus.new_key  = nk;
        @(posedge clk); #1;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            bus.in_valid = 1'($urandom);
            bus.ct       = rand128();
            bus.key      = rand128();
            bus.new_key  = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 128'(cyc), 128'(exp_lat));
        chk({tag, " pt"}, bus.pt, exp_pt);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.ct       = rand128();
            @(posedge clk); #1;
            chk({tag, " hold pt"}, bus.pt, exp_pt);
            chk({tag, " hold ctrl"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b10));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " release"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           seen;
        logic         nk;
        logic [127:0] c, k, exp;

        build_sbox();
        vecs[0] = '{ct: C1_CT, key: C1_KEY, nk: 1'b0, pt: C1_PT, lat: 20};
        vecs[1] = '{ct: C1_CT, key: JUNK,   nk: 1'b0, pt: C1_PT, lat: 10};
        vecs[2] = '{ct: B_CT,  key: B_KEY,  nk: 1'b1, pt: B_PT,  lat: 20};
        vecs[3] = '{ct: B_CT,  key: JUNK,   nk: 1'b0, pt: B_PT,  lat: 10};
        vecs[4] = '{ct: C1_CT, key: C1_KEY, nk: 1'b1, pt: C1_PT, lat: 20};

        bus.in_valid  = 1'b0;
        bus.ct        = '0;
        bus.key       = '0;
        bus.new_key   = 1'b0;
        bus.out_ready = 1'b0;
        model_cached  = 1'b0;
        model_key     = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset pt", bus.pt, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after reset", 128'(bus.in_ready), 128'd1);

        // Row 0 hits an empty cache, so it must expand despite new_key = 0.
        for (int i = 0; i < 5; i++) begin
            void'(model_accept(vecs[i].key, vecs[i].nk));
            run_req($sformatf("vec%0d", i), vecs[i].ct, vecs[i].key, vecs[i].nk,
                    vecs[i].pt, vecs[i].lat, i);
        end

        void'(model_accept(C1_KEY, 1'b1));
        run_req("backpressure", C1_CT, C1_KEY, 1'b1, C1_PT, 20, 15);

        // Cached request aborted by reset in its fifth ROUND cycle.
        bus.in_valid = 1'b1;
        bus.ct       = C1_CT;
        bus.key      = JUNK;
        bus.new_key  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_cached = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort out_valid count", 128'(seen), 128'd0);
        chk("abort in_ready", 128'(bus.in_ready), 128'd1);
        lat = model_accept(C1_KEY, 1'b0);
        run_req("after abort", C1_CT, C1_KEY, 1'b0, C1_PT, lat, 0);

        for (int n = 0; n < 24; n++) begin
            c  = rand128();
            nk = ($urandom_range(0, 2) == 0);
            k  = rand128();
            lat = model_accept(k, nk);
            exp = model_decrypt(c, model_key);
            run_req($sformatf("rand%0d", n), c, k, nk, exp, lat, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aes_128_dec_iter.md
AES_128_DEC_ITER -- requirements
Module: aes_128_dec_iter

Interface
REQ-001 SHALL have ports clk (in, 1) as the rising-edge clock and rst (in, 1) as the reset; one clock, reset synchronous and active-high.
REQ-002 SHALL have in_valid (in, 1): a ciphertext/key request is presented.
REQ-003 SHALL have in_ready (out, 1): the block accepts a request this cycle.
REQ-004 SHALL have ct (in, 128): ciphertext block, bits [127:120] = byte 0 (FIPS-197 order).
REQ-005 SHALL have key (in, 128): AES-128 cipher key, same byte order.
REQ-006 SHALL have new_key (in, 1): 1 = expand key before decrypting; 0 = reuse the cached key.
REQ-007 SHALL have out_valid (out, 1): pt holds a valid result.
REQ-008 SHALL have out_ready (in, 1): the consumer accepts pt.
REQ-009 SHALL have pt (out, 128): plaintext block, same byte order.

Function
REQ-010 SHALL perform a request handshake when in_valid and in_ready are both 1 at a rising edge, and an output handshake when out_valid and out_ready are both 1.
REQ-011 SHALL use states IDLE, KEYX, ROUND, FINAL, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL, on request accept, register ct and key, and go to KEYX if new_key = 1 or key_cached = 0; otherwise load data = ct ^ rk10_cache and go to ROUND.
REQ-013 SHALL, in KEYX, compute one forward round key per cycle (rk1..rk10) using rcon 01,02,04,08,10,20,40,80,1b,36, for exactly 10 cycles.
REQ-014 SHALL, on the last KEYX cycle, store rk10 into rk10_cache, set key_cached = 1, load data = ct ^ rk10, set the working key to rk10, and go to ROUND.
REQ-015 SHALL, in ROUND, use round counter r from 9 down to 1, one round per cycle.
REQ-016 SHALL compute each ROUND step as data <= InvMixColumns(InvSubBytes(InvShiftRows(data)) ^ rk_r).
REQ-017 SHALL derive rk_r from rk_{r+1} in the same cycle by inverse key expansion:
- w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0;
- w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon_{r+1}, 24'h0}.
REQ-018 SHALL go to FINAL after r = 1, and in FINAL compute data <= InvSubBytes(InvShiftRows(data)) ^ rk0, then go to DONE.
REQ-019 SHALL drive pt = data and hold it stable in DONE, returning to IDLE on the output handshake; no new request is accepted before that cycle ends.
REQ-020 SHALL assert out_valid exactly 10 cycles after the accepting edge with a cached key, and exactly 20 cycles after it with key expansion.
REQ-021 SHALL ignore ct, key and new_key outside the accepting cycle.
REQ-022 SHALL allow out_ready to be held low indefinitely: DONE and pt persist.

Reset
REQ-023 SHALL, when rst = 1 at a clock edge, set the state to IDLE, out_valid = 0, pt/data = 0, r = 0, key_cached = 0 and rk10_cache = 0; in_ready = 1 in the cycle after rst deasserts.
REQ-024 SHALL let reset mid-operation (KEYX, ROUND, FINAL or DONE) abort the operation with no output handshake and invalidate the cache, so the next request expands the key whatever new_key is.

Structure
REQ-025 SHALL place in package aes_dec_pkg:
- the state enum;
- the rcon table (indices 1..10);
- NR = 10;
- the byte/word widths.
REQ-026 SHALL use one sub-module, aes_sbox: combinational, 8-bit, with an inv select input, implemented as GF(2^8) inversion plus forward/inverse affine; 16 instances (inv = 1) for data, 4 instances (inv = 0) for SubWord.
REQ-027 SHALL implement InvShiftRows, InvMixColumns (x9, xB, xD, xE) and the key-schedule words as combinational logic inside aes_128_dec_iter.

Verification
REQ-028 SHALL pass the FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, new_key = 1 -> pt 00112233445566778899aabbccddeeff, out_valid 20 cycles after accept.
REQ-029 SHALL pass the FIPS-197 B vector: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32, new_key = 1 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-030 SHALL pass a cached-key check: after the REQ-029 run, ct 3925841d02dc09fbdc118597196a0b32 with new_key = 0 and key bus driven with garbage -> same pt, out_valid 10 cycles after accept.
REQ-031 SHALL pass a backpressure check: out_ready = 0 for 15 cycles after out_valid -> pt stable, in_ready = 0 throughout; out_ready = 1 -> IDLE next cycle.
REQ-032 SHALL pass a reset mid-ROUND check: rst pulse at cycle 5 of ROUND -> out_valid never asserts; next request with new_key = 0 takes 20 cycles and yields the correct pt.
REQ-033 SHALL pass a no-cache check: first request after reset with new_key = 0 (C.1 vector) -> treated as expansion, 20-cycle latency, pt 00112233445566778899aabbccddeeff.
